pwm_multi_ramp: RTL

- Parametrised multi-channel PWM generator for the rover motor drivers.
- Programmable period, prescaled clock and per-channel duty targets.
- Period and duty changes take effect only at period boundaries, so outputs never glitch.
- Each channel's active duty slews toward its target by a bounded step per period (soft-start). Sits between the drive-command logic and the H-bridge enable pins.

---
 rtl/pwm_multi_ramp.sv | 95 +++++++++
 1 files changed

// File: rtl/pwm_multi_ramp.sv
// Multi-channel PWM generator with prescaled counter, boundary-synchronous
// period/duty updates and per-channel soft-start ramping of the active duty.
module pwm_multi_ramp #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_done,
  output logic [CHANNELS-1:0]       at_target
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(RAMP_STEP);
  localparam bit               JUMP    = (RAMP_STEP == 0);

  logic [PRE_W-1:0]                 pre_cnt;
  logic [WIDTH-1:0]                 cnt;
  logic [WIDTH-1:0]                 period_reg;
  logic [CHANNELS-1:0][WIDTH-1:0]   active;
  logic [CHANNELS-1:0][WIDTH-1:0]   target;
  logic [CHANNELS-1:0][WIDTH-1:0]   active_nxt_c;
  logic                             tick_c;
  logic                             boundary_c;

  // Counter advance strobe and end-of-period detection.
  always_comb begin
    tick_c     = enable && (pre_cnt == PRE_MAX);
    boundary_c = tick_c && (cnt == period_reg);
  end

  // Next active duty: jump when within one step (or no ramping), else step toward target.
  // Stepping only when the gap exceeds STEP keeps the arithmetic free of wrap-around.
  always_comb begin
    active_nxt_c = active;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (target[k] >= active[k]) begin
        if (JUMP || ((target[k] - active[k]) <= STEP)) active_nxt_c[k] = target[k];
        else                                           active_nxt_c[k] = active[k] + STEP;
      end else begin
        if (JUMP || ((active[k] - target[k]) <= STEP)) active_nxt_c[k] = target[k];
        else                                           active_nxt_c[k] = active[k] - STEP;
      end
    end
  end

  // Prescaler, period counter, period capture and boundary pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      period_reg  <= '1;
      period_done <= 1'b0;
    end else if (!enable) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      period_done <= 1'b0;
    end else begin
      pre_cnt     <= tick_c ? '0 : pre_cnt + PRE_W'(1);
      period_done <= boundary_c;
      if (tick_c) cnt <= boundary_c ? '0 : cnt + WIDTH'(1);
      if (boundary_c) period_reg <= period;
    end
  end

  // Per-channel target capture, boundary ramp of active duty and PWM compare.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active <= '0;
      target <= '0;
      pwm    <= '0;
    end else begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        if (load) target[k] <= duty_in[k*WIDTH +: WIDTH];
        if (!enable)         active[k] <= '0;
        else if (boundary_c) active[k] <= active_nxt_c[k];
        pwm[k] <= enable && (cnt < active[k]);
      end
    end
  end

  // Channel has settled on its target.
  always_comb begin
    for (int k = 0; k < int'(CHANNELS); k++) at_target[k] = (active[k] == target[k]);
  end

endmodule
